switch_debouncer: RTL and testbench



---
 rtl/switch_debouncer.sv | 97 +++++++++
 tb/tb_switch_debouncer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronises and debounces a slide switch, emitting level, edge pulses and counters
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = 20,
  parameter int EVENT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               switch_raw,
  output logic               switch_db,
  output logic               rise_pulse,
  output logic               fall_pulse,
  output logic [EVENT_W-1:0] event_count,
  output logic [7:0]         bounce_count
);
  typedef enum logic [1:0] {STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state, state_n;
  logic sync1, sync2;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic db_n, rise_n, fall_n;
  logic [EVENT_W-1:0] ev_n;
  logic [7:0] bc_n, bc_inc;
  assign bc_inc = bounce_count == 8'hff ? bounce_count : bounce_count + 8'd1;
  // two-flop synchroniser for the asynchronous pin
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= switch_raw;
      sync2 <= sync1;
    end
  end
  // state and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= STABLE_LOW;
      cnt <= '0;
      switch_db <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      event_count <= '0;
      bounce_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      switch_db <= db_n;
      rise_pulse <= rise_n;
      fall_pulse <= fall_n;
      event_count <= ev_n;
      bounce_count <= bc_n;
    end
  end
  // qualification: a WAIT state counts agreeing samples, any contrary sample aborts
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    db_n = switch_db;
    rise_n = 1'b0;
    fall_n = 1'b0;
    ev_n = event_count;
    bc_n = bounce_count;
    case (state)
      STABLE_LOW: if (sync2) begin
        state_n = WAIT_HIGH;
        cnt_n = CNT_W'(1);
      end
      WAIT_HIGH: if (!sync2) begin
        state_n = STABLE_LOW;
        cnt_n = '0;
        bc_n = bc_inc;
      end else if (cnt == LAST) begin
        state_n = STABLE_HIGH;
        cnt_n = '0;
        db_n = 1'b1;
        rise_n = 1'b1;
        ev_n = event_count + EVENT_W'(1);
      end else cnt_n = cnt + CNT_W'(1);
      STABLE_HIGH: if (!sync2) begin
        state_n = WAIT_LOW;
        cnt_n = CNT_W'(1);
      end
      WAIT_LOW: if (sync2) begin
        state_n = STABLE_HIGH;
        cnt_n = '0;
        bc_n = bc_inc;
      end else if (cnt == LAST) begin
        state_n = STABLE_LOW;
        cnt_n = '0;
        db_n = 1'b0;
        fall_n = 1'b1;
      end else cnt_n = cnt + CNT_W'(1);
      default: state_n = STABLE_LOW;
    endcase
  end
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: scoreboard bench comparing the debouncer with a run-length reference model
module tb_switch_debouncer;
  localparam int D = 4;
  localparam int EW = 2;
  logic clock = 1'b0, reset = 1'b1, switch_raw = 1'b0;
  logic switch_db, rise_pulse, fall_pulse;
  logic [EW-1:0] event_count;
  logic [7:0] bounce_count;
  typedef struct {bit rise; int cyc;} item_t;
  item_t q[$];
  int checks = 0, failures = 0, edge_n = 0;
  int run_len = 0, m_ev = 0, m_bc = 0;
  bit h1 = 0, h2 = 0, m_db = 0, mon_en = 0;
  bit pat[8] = '{1, 1, 0, 1, 1, 1, 1, 1};
  switch_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(3), .EVENT_W(EW)) dut (
    .clock(clock), .reset(reset), .switch_raw(switch_raw), .switch_db(switch_db),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .event_count(event_count),
    .bounce_count(bounce_count)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  // model: the FSM sees the pin two edges late; a run of D samples differing from
  // the accepted level flips it, a run cut short by an agreeing sample is a bounce
  task automatic tick(input bit r, input bit rst);
    bit s;
    switch_raw = r;
    reset = rst;
    @(posedge clock);
    edge_n++;
    if (rst) begin
      h1 = 0; h2 = 0; m_db = 0; run_len = 0; m_ev = 0; m_bc = 0;
    end else begin
      s = h2; h2 = h1; h1 = r;
      if (s != m_db) begin
        run_len++;
        if (run_len == D) begin
          m_db = s;
          run_len = 0;
          if (s) m_ev = (m_ev + 1) % (1 << EW);
          q.push_back('{s, edge_n});
        end
      end else if (run_len > 0) begin
        m_bc = m_bc == 255 ? 255 : m_bc + 1;
        run_len = 0;
      end
    end
    #1;
  endtask
  // monitor: levels every cycle, pulses matched against the scoreboard queue
  always @(negedge clock) begin
    if (mon_en) begin
      check("switch_db", int'(switch_db), int'(m_db));
      check("bounce_count", int'(bounce_count), m_bc);
      check("event_count", int'(event_count), m_ev);
      if (rise_pulse && fall_pulse) check("pulses_together", 1, 0);
      while (q.size() > 0 && q[0].cyc < edge_n) begin
        check("missed_pulse_cycle", edge_n, q[0].cyc);
        void'(q.pop_front());
      end
      if (rise_pulse || fall_pulse) begin
        if (q.size() == 0) check("unexpected_pulse", 1, 0);
        else begin
          check("pulse_cycle", edge_n, q[0].cyc);
          check("pulse_is_rise", int'(rise_pulse), int'(q[0].rise));
          void'(q.pop_front());
        end
      end
    end
  end
  initial begin
    tick(1, 1);
    mon_en = 1;
    repeat (2) tick(1, 1);
    repeat (12) tick(1, 0);
    check("reset_rise_event", int'(event_count), 1);
    repeat (12) tick(0, 0);
    repeat (20) tick(1, 0);
    repeat (12) tick(0, 0);
    foreach (pat[i]) tick(pat[i], 0);
    repeat (10) tick(1, 0);
    check("bounce_once", int'(bounce_count), 1);
    repeat (12) tick(0, 0);
    check("release_level", int'(switch_db), 0);
    repeat (4) tick(1, 0);
    tick(1, 1);
    repeat (10) tick(0, 0);
    check("midwindow_reset_db", int'(switch_db), 0);
    repeat (60) begin
      if ($urandom_range(0, 15) == 0) tick(0, 1);
      begin
        bit lvl;
        int len;
        lvl = 1'($urandom_range(0, 1));
        len = $urandom_range(1, 8);
        repeat (len) tick(lvl, 0);
      end
    end
    repeat (2) tick(0, 1);
    repeat (300) begin
      tick(1, 0);
      tick(0, 0);
    end
    repeat (5) begin
      repeat (8) tick(1, 0);
      repeat (8) tick(0, 0);
    end
    repeat (4) tick(0, 0);
    check("bounce_saturated", int'(bounce_count), 255);
    check("event_wrapped", int'(event_count), 1);
    mon_en = 0;
    check("pending_pulses", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
